alu16: RTL and testbench
========================

Name: alu16

Overview:
16-bit arithmetic/logic unit for the datapath. Combinational result path: operand-B conditioning (zero, invert), an adder with a carry-in and a carry-suppress (XOR) mode, AND/OR, and a barrel shifter. One clocked element, a 4-bit status-flag register, captures the result flags on demand for later branch/condition logic.

Parameters:
- WIDTH, 16, operand/result width; all behaviour below written for 16.

Ports:
- clk  in  1  system clock; flag register updates on rising edge.
- rst  in  1  synchronous, active-high reset; clears flag register.
- a  in  16  operand A.
- b  in  16  operand B.
- ci  in  1  adder carry-in.
- nb  in  1  invert conditioned B.
- ic  in  1  ignore carry: adder path yields bitwise sum without carry propagation (XOR).
- zb  in  1  zero B before inversion.
- sel  in  3  function select (see Behaviour).
- flag_we  in  1  capture flags of current result on next clk edge.
- out  out  16  combinational result.
- co  out  1  combinational carry/shift-out.
- flags  out  4  registered status: [3]=Z, [2]=N, [1]=C, [0]=V.

Behaviour:
- One clock (clk) and one reset (rst), synchronous active-high; only flags is registered.
- Operand conditioning, in order: b0 = zb ? 0 : b; bx = nb ? ~b0 : b0.
- sel=000 adder path, and any undefined code 110/111:
  - ic=0: {co,out} = a + bx + ci (17-bit), mod 2^16.
  - ic=1: out = a ^ bx; co = 0; ci ignored.
- sel=001: out = a & bx; co = 0.
- sel=010: out = a | bx; co = 0.
- Shift amount n = bx[3:0]. For n=0: out = a, co = 0.
- sel=011: out = a << n. co = a[16-n], the last bit shifted out.
- sel=100: out = a >> n, zero fill. co = a[n-1].
- sel=101: out = a >>> n, sign fill from a[15]. co = a[n-1].
- Derived operations (no dedicated codes):
  - SUB: nb=1, ci=1.
  - INC: zb=1, ci=1.
  - DEC: zb=1, nb=1, ci=0.
  - XOR: ic=1.
  - NOT a: ic=1, zb=1, nb=1.
- out and co are purely combinational. No latency. Valid within the same delta as input change; independent of clk/rst.
- Flag values:
  - Z = (out==0).
  - N = out[15].
  - C = co.
  - V = signed overflow: only sel adder path with ic=0, (a[15]==bx[15]) && (out[15]!=a[15]); 0 otherwise.
- Flag register update on rising clk, in priority order:
  - rst=1: flags <= 0000.
  - else flag_we=1: flags <= {Z,N,C,V}.
  - else hold.
  - rst wins over simultaneous flag_we.
- Reset value: flags = 4'b0000. out/co have no reset value; they follow inputs even during reset.
- Wrap-around: 65534+2 → out=0, co=1; 65534+1 → out=65535, co=0. Signed interpretation of out is two's complement (7 + -9 → 0xFFFE, -2).

Test Plan:
- Add: sel=000, all mode bits 0.
  - a=9, b=8 → out=17, co=0.
  - a=7, b=0xFFFA → out=1, co=1.
  - a=7, b=0xFFF7 → out=0xFFFE (signed -2).
  - a=65534, b=1 → out=65535, co=0.
  - a=65534, b=2 → out=0, co=1.
- Sub/XOR/INC/DEC, sel=000:
  - nb=1, ci=1, a=10, b=4 → out=6.
  - ic=1, a=10, b=9 → out=3, co=0.
  - zb=1, ci=1, a=16 → out=17.
  - zb=1, nb=1, a=16 → out=15.
- Logic:
  - sel=001, a=0x00F0, b=0x0FF0 → out=0x00F0.
  - sel=010, same operands → out=0x0FF0.
  - ic=1, zb=1, nb=1, a=0x1234 → out=0xEDCB.
- Shifts, a=0x8001, b=1:
  - sel=011 → out=0x0002, co=1.
  - sel=100 → out=0x4000, co=1.
  - sel=101 → out=0xC000, co=1.
  - b=0 with any shift code → out=0x8001, co=0.
- Flags:
  - a=0x7FFF, b=1, sel=000, flag_we=1, one clk → flags=0101 (N=1, V=1).
  - a=65534, b=2, flag_we=1 → flags=1010 (Z=1, C=1).
  - flag_we=0 → flags hold across clk edges.
- Reset: assert rst with flag_we=1 for one clk → flags=0000. out still equals combinational result during reset.

Source files
------------

// File: rtl/alu16.sv
// alu16: 16-bit ALU with B conditioning, adder/xor, logic, shifter.
// Ports: clk, rst (sync high), a, b, ci, nb, ic, zb, sel, flag_we,
//        out/co (combinational), flags {Z,N,C,V} (registered).
module alu16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             nb,
  input  logic             ic,
  input  logic             zb,
  input  logic [2:0]       sel,
  input  logic             flag_we,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic [3:0]       flags
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] bx;
  logic [SW-1:0]    n;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [WIDTH:0]   sra;
  logic             is_and;
  logic             is_or;
  logic             is_shl;
  logic             is_shr;
  logic             is_sra;
  logic             is_add;
  logic             fz;
  logic             fn;
  logic             fv;

  assign b0 = zb ? '0 : b;
  assign bx = nb ? ~b0 : b0;
  assign n  = bx[SW-1:0];

  assign sum = {1'b0, a} + {1'b0, bx}
             + {{WIDTH{1'b0}}, ci};

  // Extra bit catches the last bit shifted out;
  // it is naturally 0 when n == 0.
  assign shl = {1'b0, a} << n;
  assign shr = {a, 1'b0} >> n;
  assign sra = $unsigned($signed({a, 1'b0}) >>> n);

  assign is_and = (sel == 3'b001);
  assign is_or  = (sel == 3'b010);
  assign is_shl = (sel == 3'b011);
  assign is_shr = (sel == 3'b100);
  assign is_sra = (sel == 3'b101);
  assign is_add = !(is_and || is_or || is_shl
                 || is_shr || is_sra);

  always_comb begin
    out = '0;
    co  = 1'b0;
    unique case (1'b1)
      is_and: out = a & bx;
      is_or:  out = a | bx;
      is_shl: {co, out} = shl;
      is_shr: {out, co} = shr;
      is_sra: {out, co} = sra;
      default: begin
        if (ic) begin
          out = a ^ bx;
        end else begin
          {co, out} = sum;
        end
      end
    endcase
  end

  assign fz = (out == '0);
  assign fn = out[WIDTH-1];
  assign fv = is_add && !ic
           && (a[WIDTH-1] == bx[WIDTH-1])
           && (out[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (flag_we) begin
      flags <= {fz, fn, co, fv};
    end
  end

endmodule

// File: tb/tb_alu16.sv
// tb_alu16: directed self-checking bench for alu16.
// Hand-computed vectors for arithmetic, logic, shifts and flags.
module tb_alu16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        nb;
  logic        ic;
  logic        zb;
  logic [2:0]  sel;
  logic        flag_we;
  logic [15:0] out;
  logic        co;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_bad = 0;

  alu16 dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .ci(ci), .nb(nb), .ic(ic), .zb(zb),
    .sel(sel), .flag_we(flag_we),
    .out(out), .co(co), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic op(input logic [2:0] s,
                    input logic [15:0] va,
                    input logic [15:0] vb,
                    input logic [3:0] m);
    sel = s;
    a   = va;
    b   = vb;
    {zb, nb, ic, ci} = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode bits order: {zb, nb, ic, ci}
  initial begin
    rst = 1'b1;
    flag_we = 1'b0;
    op(3'b000, 16'd0, 16'd0, 4'b0000);
    tick();
    chk("rst_flags", {12'd0, flags}, 16'h0000);
    rst = 1'b0;

    op(3'b000, 16'd9, 16'd8, 4'b0000);
    chk("add_out", out, 16'd17);
    chk("add_co", {15'd0, co}, 16'd0);
    op(3'b000, 16'd7, 16'hFFFA, 4'b0000);
    chk("addc_out", out, 16'd1);
    chk("addc_co", {15'd0, co}, 16'd1);
    op(3'b000, 16'd7, 16'hFFF7, 4'b0000);
    chk("addneg_out", out, 16'hFFFE);
    op(3'b000, 16'd65534, 16'd1, 4'b0000);
    chk("max_out", out, 16'hFFFF);
    chk("max_co", {15'd0, co}, 16'd0);
    op(3'b000, 16'd65534, 16'd2, 4'b0000);
    chk("wrap_out", out, 16'h0000);
    chk("wrap_co", {15'd0, co}, 16'd1);
    op(3'b110, 16'd9, 16'd8, 4'b0000);
    chk("sel110_out", out, 16'd17);
    op(3'b111, 16'd9, 16'd8, 4'b0001);
    chk("sel111_out", out, 16'd18);

    op(3'b000, 16'd10, 16'd4, 4'b0101);
    chk("sub_out", out, 16'd6);
    op(3'b000, 16'd10, 16'd9, 4'b0011);
    chk("xor_out", out, 16'd3);
    chk("xor_co", {15'd0, co}, 16'd0);
    op(3'b000, 16'd16, 16'h5555, 4'b1001);
    chk("inc_out", out, 16'd17);
    op(3'b000, 16'd16, 16'h5555, 4'b1100);
    chk("dec_out", out, 16'd15);

    op(3'b001, 16'h00F0, 16'h0FF0, 4'b0000);
    chk("and_out", out, 16'h00F0);
    op(3'b010, 16'h00F0, 16'h0FF0, 4'b0000);
    chk("or_out", out, 16'h0FF0);
    op(3'b000, 16'h1234, 16'h0F0F, 4'b1110);
    chk("not_out", out, 16'hEDCB);

    op(3'b011, 16'h8001, 16'd1, 4'b0000);
    chk("shl1_out", out, 16'h0002);
    chk("shl1_co", {15'd0, co}, 16'd1);
    op(3'b100, 16'h8001, 16'd1, 4'b0000);
    chk("shr1_out", out, 16'h4000);
    chk("shr1_co", {15'd0, co}, 16'd1);
    op(3'b101, 16'h8001, 16'd1, 4'b0000);
    chk("sra1_out", out, 16'hC000);
    chk("sra1_co", {15'd0, co}, 16'd1);
    for (int s = 3; s <= 5; s++) begin
      op(3'(s), 16'h8001, 16'd0, 4'b0000);
      chk("sh0_out", out, 16'h8001);
      chk("sh0_co", {15'd0, co}, 16'd0);
    end
    op(3'b011, 16'h8001, 16'd4, 4'b0000);
    chk("shl4_out", out, 16'h0010);
    chk("shl4_co", {15'd0, co}, 16'd0);
    op(3'b011, 16'h0003, 16'd15, 4'b0000);
    chk("shl15_out", out, 16'h8000);
    chk("shl15_co", {15'd0, co}, 16'd1);
    op(3'b101, 16'hF00F, 16'd4, 4'b0000);
    chk("sra4_out", out, 16'hFF00);
    chk("sra4_co", {15'd0, co}, 16'd1);
    op(3'b100, 16'h8001, 16'h0014, 4'b0000);
    chk("shr4_out", out, 16'h0800);
    chk("shr4_co", {15'd0, co}, 16'd0);

    flag_we = 1'b1;
    op(3'b000, 16'h7FFF, 16'd1, 4'b0000);
    tick();
    chk("flg_nv", {12'd0, flags}, 16'h0005);
    op(3'b000, 16'd65534, 16'd2, 4'b0000);
    tick();
    chk("flg_zc", {12'd0, flags}, 16'h000A);
    flag_we = 1'b0;
    op(3'b000, 16'h7FFF, 16'd1, 4'b0000);
    tick();
    tick();
    chk("flg_hold", {12'd0, flags}, 16'h000A);
    flag_we = 1'b1;
    op(3'b001, 16'h8000, 16'h8000, 4'b0000);
    tick();
    chk("flg_and_nov", {12'd0, flags}, 16'h0004);

    rst = 1'b1;
    op(3'b000, 16'd9, 16'd8, 4'b0000);
    tick();
    chk("rst_wins", {12'd0, flags}, 16'h0000);
    chk("rst_out", out, 16'd17);
    rst = 1'b0;
    flag_we = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
